fifo_rd_ctrl: RTL and testbench

Read-side controller for the dual-clock FIFO: it is the reader that pairs with the write-side controller that publishes a Gray-coded write pointer. Lives entirely in the read clock domain. It synchronizes the incoming write pointer, computes emptiness and occupancy, and drives the storage array's read port. It presents a first-word-fall-through stream to the consumer through a 2-entry output buffer, which hides the array's 1-cycle read latency and sustains one pop per cycle.

---
 rtl/fifo_rd_ctrl.sv | 124 ++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO: synchronizes the Gray write pointer,
// issues array reads and serves a first-word-fall-through stream via a 2-entry buffer.
module fifo_rd_ctrl #(
  parameter int W_DATA = 8,
  parameter int W_ADDR = 4,
  localparam int ADDR_GRAY = W_ADDR + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_GRAY-1:0] wr_ptr_gray_i,
  output logic [ADDR_GRAY-1:0] rd_ptr_gray_o,
  output logic [W_ADDR-1:0]    rd_addr_o,
  output logic                 rd_en_o,
  input  logic [W_DATA-1:0]    rd_data_i,
  input  logic                 pop_i,
  output logic [W_DATA-1:0]    data_o,
  output logic                 valid_o,
  output logic                 empty_o,
  output logic [ADDR_GRAY-1:0] count_o,
  output logic                 pop_err_o
);

  typedef enum logic {NO_POP = 1'b0, POP = 1'b1} pop_e_t;

  function automatic logic [ADDR_GRAY-1:0] bin2gray(input logic [ADDR_GRAY-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_GRAY-1:0] gray2bin(input logic [ADDR_GRAY-1:0] g);
    logic [ADDR_GRAY-1:0] b;
    b[ADDR_GRAY-1] = g[ADDR_GRAY-1];
    for (int i = ADDR_GRAY - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Handshake: a word leaves on an edge where valid_o=1 and pop_i=POP;
  // pop_i=POP with valid_o=0 is refused and flagged on pop_err_o next cycle.

  logic [ADDR_GRAY-1:0] wr_sync1, wr_sync2;
  logic [ADDR_GRAY-1:0] wr_bin;
  logic [ADDR_GRAY-1:0] rd_bin, rd_bin_next;
  logic                 inflight;
  logic [W_DATA-1:0]    head, tail, head_next, tail_next;
  logic [1:0]           buf_cnt, buf_cnt_next;
  logic                 arr_nonempty;
  logic                 pop_req;
  logic                 pop_fire;
  logic [2:0]           occupancy;

  assign pop_req      = (pop_e_t'(pop_i) == POP);
  assign valid_o      = (buf_cnt != 2'd0);
  assign empty_o      = !valid_o;
  assign data_o       = head;
  assign pop_fire     = pop_req && valid_o;
  assign wr_bin       = gray2bin(wr_sync2);
  assign arr_nonempty = (bin2gray(rd_bin) != wr_sync2);
  assign rd_addr_o    = rd_bin[W_ADDR-1:0];

  // Words the buffer will hold after this edge if no new read is issued; pop_fire
  // implies buf_cnt>=1, so the subtraction never goes negative.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop_fire};
  assign rd_en_o   = arr_nonempty && (occupancy < 3'd2);

  assign rd_bin_next = rd_en_o ? rd_bin + 1'b1 : rd_bin;

  assign count_o = (wr_bin - rd_bin) + {{(ADDR_GRAY-1){1'b0}}, inflight}
                 + {{(ADDR_GRAY-2){1'b0}}, buf_cnt};

  always_comb begin
    head_next    = head;
    tail_next    = tail;
    buf_cnt_next = buf_cnt;
    unique case ({inflight, pop_fire})
      2'b10: begin
        if (buf_cnt == 2'd0) head_next = rd_data_i;
        else                 tail_next = rd_data_i;
        buf_cnt_next = buf_cnt + 2'd1;
      end
      2'b01: begin
        head_next    = tail;
        buf_cnt_next = buf_cnt - 2'd1;
      end
      2'b11: begin
        // Capture and pop together: the arriving word queues behind any survivor.
        if (buf_cnt == 2'd1) begin
          head_next = rd_data_i;
        end else begin
          head_next = tail;
          tail_next = rd_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sync1      <= '0;
      wr_sync2      <= '0;
      rd_bin        <= '0;
      rd_ptr_gray_o <= '0;
      inflight      <= 1'b0;
      head          <= '0;
      tail          <= '0;
      buf_cnt       <= 2'd0;
      pop_err_o     <= 1'b0;
    end else begin
      wr_sync1      <= wr_ptr_gray_i;
      wr_sync2      <= wr_sync1;
      rd_bin        <= rd_bin_next;
      rd_ptr_gray_o <= bin2gray(rd_bin_next);
      inflight      <= rd_en_o;
      head          <= head_next;
      tail          <= tail_next;
      buf_cnt       <= buf_cnt_next;
      pop_err_o     <= pop_req && !valid_o;
    end
  end

  a_buf_cnt_le2 : assert property (@(posedge clk) disable iff (!rst_n) buf_cnt <= 2'd2);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: models the storage array and the write-side pointer,
// checks outputs against hand-derived values and a queue of written words.
module tb_fifo_rd_ctrl;

  localparam int W_DATA = 8;
  localparam int W_ADDR = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [W_ADDR:0]   wr_ptr_gray = '0;
  logic [W_ADDR:0]   rd_ptr_gray_o;
  logic [W_ADDR-1:0] rd_addr_o;
  logic              rd_en_o;
  logic [W_DATA-1:0] rd_data = '0;
  logic              pop_i = 1'b0;
  logic [W_DATA-1:0] data_o;
  logic              valid_o;
  logic              empty_o;
  logic [W_ADDR:0]   count_o;
  logic              pop_err_o;

  logic [W_DATA-1:0] mem [16];
  logic [W_ADDR:0]   wr_bin_tb = '0;
  logic [W_DATA-1:0] exp_q [$];
  int                n_cmp = 0;
  int                n_err = 0;

  fifo_rd_ctrl #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_ptr_gray_i (wr_ptr_gray),
    .rd_ptr_gray_o (rd_ptr_gray_o),
    .rd_addr_o     (rd_addr_o),
    .rd_en_o       (rd_en_o),
    .rd_data_i     (rd_data),
    .pop_i         (pop_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .empty_o       (empty_o),
    .count_o       (count_o),
    .pop_err_o     (pop_err_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // storage array: one-cycle registered read
  always @(posedge clk) begin
    if (rd_en_o) rd_data <= mem[rd_addr_o];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic write_word(input logic [W_DATA-1:0] d);
    mem[wr_bin_tb[W_ADDR-1:0]] = d;
    wr_bin_tb   = wr_bin_tb + 1'b1;
    wr_ptr_gray = wr_bin_tb ^ (wr_bin_tb >> 1);
    exp_q.push_back(d);
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_head(input string tag);
    logic [W_DATA-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(data_o), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(data_o), 32'(e));
    end
  endtask

  initial begin
    int pulses;
    int wrote;
    int got;
    int addr_wraps;
    bit have_last;
    bit gray_wrap;
    logic [W_ADDR-1:0] last_addr;
    logic [W_ADDR:0]   prev_gray;

    // reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_ptr_gray = 5'($urandom_range(0, 31));
      pop_i       = 1'($urandom_range(0, 1));
      cyc();
    end
    #1;
    check("rst_gray",    32'(rd_ptr_gray_o), 0);
    check("rst_addr",    32'(rd_addr_o), 0);
    check("rst_rd_en",   32'(rd_en_o), 0);
    check("rst_data",    32'(data_o), 0);
    check("rst_valid",   32'(valid_o), 0);
    check("rst_empty",   32'(empty_o), 1);
    check("rst_count",   32'(count_o), 0);
    check("rst_pop_err", 32'(pop_err_o), 0);
    wr_ptr_gray = '0;
    pop_i       = 1'b0;
    rst_n       = 1'b1;
    cyc();

    // single word: pointer change before E0
    write_word(8'hA5);
    #1; check("sw_rd_en_pre", 32'(rd_en_o), 0);
    cyc(); #1; check("sw_rd_en_e0", 32'(rd_en_o), 0);
    cyc(); #1;
    check("sw_rd_en_e1", 32'(rd_en_o), 1);
    check("sw_addr_e1",  32'(rd_addr_o), 0);
    check("sw_count_e1", 32'(count_o), 1);
    cyc(); #1;
    check("sw_gray_e2",  32'(rd_ptr_gray_o), 1);
    check("sw_rd_en_e2", 32'(rd_en_o), 0);
    cyc(); #1;
    check("sw_valid", 32'(valid_o), 1);
    check("sw_data",  32'(data_o), 32'hA5);
    check("sw_count", 32'(count_o), 1);
    pop_i = 1'b1;
    #1; expect_head("sw_pop_data");
    cyc();
    pop_i = 1'b0;
    #1;
    check("sw_valid_after_pop", 32'(valid_o), 0);
    check("sw_gray_after_pop",  32'(rd_ptr_gray_o), 5'b00001);
    check("sw_count_after_pop", 32'(count_o), 0);

    // pop while empty
    pop_i = 1'b1;
    cyc();
    pop_i = 1'b0;
    #1;
    check("err_pulse", 32'(pop_err_o), 1);
    check("err_gray",  32'(rd_ptr_gray_o), 5'b00001);
    check("err_count", 32'(count_o), 0);
    cyc(); #1;
    check("err_pulse_end", 32'(pop_err_o), 0);

    // streaming with pop held
    pop_i = 1'b1;
    for (int i = 1; i <= 4; i++) write_word(8'(i));
    for (int w = 0; w < 20 && !valid_o; w++) begin
      cyc(); #1;
    end
    check("stream_first_valid", 32'(valid_o), 1);
    for (int k = 0; k < 4; k++) begin
      check("stream_valid", 32'(valid_o), 1);
      expect_head("stream_data");
      cyc(); #1;
    end
    pop_i = 1'b0;
    #1;
    check("stream_valid_end", 32'(valid_o), 0);
    check("stream_count_end", 32'(count_o), 0);
    cyc();

    // backpressure: three words, no pops
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rd_en_o) pulses++;
      cyc();
    end
    #1;
    check("bp_rd_pulses", 32'(pulses), 2);
    check("bp_rd_en_idle", 32'(rd_en_o), 0);
    check("bp_count",  32'(count_o), 3);
    check("bp_valid",  32'(valid_o), 1);
    pop_i = 1'b1;
    #1;
    check("bp_third_read_on_pop", 32'(rd_en_o), 1);
    expect_head("bp_data0");
    cyc(); #1;
    check("bp_valid1", 32'(valid_o), 1);
    expect_head("bp_data1");
    cyc(); #1;
    check("bp_valid2", 32'(valid_o), 1);
    expect_head("bp_data2");
    cyc();
    pop_i = 1'b0;
    #1;
    check("bp_valid_end", 32'(valid_o), 0);
    check("bp_count_end", 32'(count_o), 0);
    cyc();

    // wrap: 40 words pushed and popped continuously
    wrote = 0; got = 0; addr_wraps = 0;
    have_last = 1'b0; gray_wrap = 1'b0; last_addr = '0;
    prev_gray = rd_ptr_gray_o;
    for (int c = 0; c < 300 && got < 40; c++) begin
      if (wrote < 40) begin
        write_word(8'(8'h40 + wrote));
        wrote++;
      end
      pop_i = 1'b1;
      #1;
      if (rd_en_o) begin
        if (have_last && last_addr == 4'd15 && rd_addr_o == 4'd0) addr_wraps++;
        last_addr = rd_addr_o;
        have_last = 1'b1;
      end
      if (rd_ptr_gray_o != prev_gray) begin
        check("wrap_gray_1bit", 32'($countones(rd_ptr_gray_o ^ prev_gray)), 1);
        if (prev_gray == 5'b10000 && rd_ptr_gray_o == 5'b00000) gray_wrap = 1'b1;
        prev_gray = rd_ptr_gray_o;
      end
      if (valid_o) begin
        expect_head("wrap_data");
        got++;
      end
      cyc();
    end
    pop_i = 1'b0;
    #1;
    check("wrap_delivered",  32'(got), 40);
    check("wrap_addr_wraps", 32'(addr_wraps), 2);
    check("wrap_gray_wrap",  32'(gray_wrap), 1);
    check("wrap_queue_left", 32'(exp_q.size()), 0);
    check("wrap_count_end",  32'(count_o), 0);
    cyc();

    // mid-operation reset with a full output buffer
    write_word(8'h77);
    write_word(8'h88);
    write_word(8'h99);
    for (int c = 0; c < 10; c++) cyc();
    #1;
    check("mr_count_pre", 32'(count_o), 3);
    check("mr_valid_pre", 32'(valid_o), 1);
    rst_n       = 1'b0;
    wr_bin_tb   = '0;
    wr_ptr_gray = '0;
    exp_q.delete();
    cyc(); #1;
    check("mr_valid", 32'(valid_o), 0);
    check("mr_count", 32'(count_o), 0);
    check("mr_empty", 32'(empty_o), 1);
    rst_n = 1'b1;
    cyc(); cyc(); cyc(); #1;
    check("mr_count_after", 32'(count_o), 0);
    check("mr_rd_en_after", 32'(rd_en_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
